// File: rtl/prmcu_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : prmcu_uart_receiver
// Brief    : UART receive path; oversampled deserialiser feeding a valid/ready
//            word buffer with parity, framing and overrun flags.
//            Optional: PRMCU_UART_RX_MAJORITY_EN selects 3-sample majority voting.
// Revision : 1.0 - initial release
// ============================================================================
module prmcu_uart_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_en,
  input  logic              rx_en,
  input  logic              n_parity_bits_i,
  input  logic [1:0]        n_stop_bits_i,
  input  logic [3:0]        n_data_bits_i,
  input  logic [7:0]        internal_clk_divider_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] out_dat_o,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  localparam logic [3:0] c_MIN_BITS = 4'd5;
  localparam logic [3:0] c_MAX_BITS = 4'(DATA_W);
  localparam logic [7:0] c_MIN_DIV  = 8'd4;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_prev;
  state_t                 r_state, w_state_next;
  logic [7:0]             r_div, r_cnt, w_half;
  logic [3:0]             r_nbits, r_bit_cnt;
  logic                   r_par_en, r_two_stop, r_stop_cnt;
  logic [DATA_W-1:0]      r_shift;
  logic                   r_perr, r_ferr;
  logic                   w_rxs, w_en, w_fall, w_samp, w_bit, w_bit_end;
  logic                   w_start, w_done, w_ferr_now;

  assign w_rxs      = r_sync[SYNC_STAGES-1];
  assign w_en       = uart_en & rx_en;
  assign w_fall     = r_rxs_prev & ~w_rxs;
  assign w_half     = {1'b0, r_div[7:1]};
  assign w_bit_end  = (r_cnt == r_div - 8'd1);
  assign w_ferr_now = r_ferr | ~w_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync     <= '1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], rx_i};
      r_rxs_prev <= w_rxs;
    end
  end

`ifdef PRMCU_UART_RX_MAJORITY_EN
  logic r_s0, r_s1;

  // Two early samples are held so the vote completes on the third one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      if (r_cnt == w_half - 8'd1) r_s0 <= w_rxs;
      if (r_cnt == w_half)        r_s1 <= w_rxs;
    end
  end

  assign w_samp = (r_cnt == w_half + 8'd1);
  assign w_bit  = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
`else
  assign w_samp = (r_cnt == w_half);
  assign w_bit  = w_rxs;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_next = S_START;
          w_start      = 1'b1;
        end
      end
      S_START: begin
        if (w_samp && w_bit) w_state_next = S_IDLE;
        else if (w_bit_end)  w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && (r_bit_cnt == r_nbits - 4'd1))
          w_state_next = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
      S_STOP: begin
        // The word is handed over at mid-bit of the final stop bit.
        if (w_samp && (r_stop_cnt == r_two_stop)) begin
          w_done       = 1'b1;
          w_state_next = w_bit ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (w_rxs) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (!w_en) begin
      w_state_next = S_IDLE;
      w_start      = 1'b0;
      w_done       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 8'd0;
      r_div      <= 8'd0;
      r_nbits    <= 4'd0;
      r_par_en   <= 1'b0;
      r_two_stop <= 1'b0;
      r_bit_cnt  <= 4'd0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      if (r_state == S_IDLE || r_state == S_BREAK || w_bit_end) r_cnt <= 8'd0;
      else                                                      r_cnt <= r_cnt + 8'd1;

      if (w_start) begin
        r_div      <= (internal_clk_divider_i < c_MIN_DIV) ? c_MIN_DIV : internal_clk_divider_i;
        r_nbits    <= (n_data_bits_i < c_MIN_BITS) ? c_MIN_BITS :
                      (n_data_bits_i > c_MAX_BITS) ? c_MAX_BITS : n_data_bits_i;
        r_par_en   <= n_parity_bits_i;
        r_two_stop <= (n_stop_bits_i >= 2'd2);
        r_bit_cnt  <= 4'd0;
        r_stop_cnt <= 1'b0;
        r_shift    <= '0;
        r_perr     <= 1'b0;
        r_ferr     <= 1'b0;
      end

      if (r_state == S_DATA) begin
        if (w_samp)    r_shift[r_bit_cnt] <= w_bit;
        if (w_bit_end) r_bit_cnt <= r_bit_cnt + 4'd1;
      end

      // Unused upper bits of r_shift are zero, so a full-width XOR is exact.
      if (r_state == S_PARITY && w_samp) r_perr <= w_bit ^ (^r_shift);

      if (r_state == S_STOP) begin
        if (w_samp && !w_bit) r_ferr <= 1'b1;
        if (w_bit_end)        r_stop_cnt <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_dat_o     <= '0;
      out_vld_o     <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      overrun_err_o <= 1'b0;
      if (w_done) begin
        if (!out_vld_o || out_rdy_i) begin
          out_dat_o    <= r_shift;
          parity_err_o <= r_perr;
          frame_err_o  <= w_ferr_now;
          out_vld_o    <= 1'b1;
        end else begin
          overrun_err_o <= 1'b1;
        end
      end else if (out_vld_o && out_rdy_i) begin
        out_vld_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
